// File: rtl/noc_input_unit.sv
// Per-port router input stage: flit FIFO, XY routing of head flits, and one
// crossbar request per cycle that is held for the routed packet.
module noc_input_unit #(
  parameter int FLIT_W  = 34,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 4,
  parameter int X_ID    = 0,
  parameter int Y_ID    = 0,
  parameter int PORT_N  = 5,
  parameter int PORT_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [FLIT_W-1:0] flit_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [FLIT_W-1:0] flit_o,
  output logic              req_o,
  output logic [PORT_W-1:0] port_o,
  input  logic [PORT_N-1:0] grt_i,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [COORD_W-1:0] X_POS = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] Y_POS = COORD_W'(Y_ID);

  typedef enum logic {
    IDLE,
    ROUTED
  } state_t;

  state_t              state;
  logic [FLIT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                front_head;
  logic                front_last;
  logic [PORT_W-1:0]   port_q;

  // XY dimension-order routing: resolve X first, then Y, else eject locally.
  function automatic logic [PORT_W-1:0] route(input logic [FLIT_W-1:0] f);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = f[COORD_W-1:0];
    dy = f[2*COORD_W-1:COORD_W];
    if (dx > X_POS)      return PORT_W'(2);
    else if (dx < X_POS) return PORT_W'(4);
    else if (dy > Y_POS) return PORT_W'(1);
    else if (dy < Y_POS) return PORT_W'(3);
    else                 return PORT_W'(0);
  endfunction

  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == PTR_W'(DEPTH));
  assign empty      = (count == '0);
  assign ready_o    = !full;
  assign push       = valid_i && ready_o;
  assign flit_o     = mem[rd_ptr[IDX_W-1:0]];
  assign front_head = flit_o[FLIT_W-2];
  assign front_last = flit_o[FLIT_W-1];
  assign port_o     = port_q;

  // In IDLE a non-head flit at the front is an orphan and is discarded.
  always_comb begin
    pop   = 1'b0;
    req_o = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty && !front_head;
      end
      ROUTED: begin
        req_o = !empty;
        pop   = !empty && grt_i[port_q];
      end
      default: begin
        pop   = 1'b0;
        req_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[IDX_W-1:0]] <= flit_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= IDLE;
      port_q <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            if (front_head) begin
              port_q <= route(flit_o);
              state  <= ROUTED;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ROUTED: begin
          if (pop && front_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
